// File: rtl/pc_pkg.sv
// Shared types and default constants for the fetch-stage program-counter unit.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    PEND
  } pc_state_e;

  typedef enum logic [2:0] {
    SEL_EXC,
    SEL_ERET,
    SEL_JMP,
    SEL_BR,
    SEL_SEQ
  } pc_sel_e;

  localparam logic [31:0] PC_DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] PC_DEFAULT_EXC_VECTOR   = 32'h8000_0180;
  localparam int unsigned PC_DEFAULT_STEP         = 4;

endpackage

// File: rtl/pc_next_sel.sv
// Prioritised next-PC selection with alignment masking of every redirect target.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int unsigned     WIDTH      = 32,
  parameter int unsigned     STEP       = PC_DEFAULT_STEP,
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(PC_DEFAULT_EXC_VECTOR)
) (
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] epc,
  input  logic             exc,
  input  logic             eret,
  input  logic             jmp,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  output pc_sel_e          sel,
  output logic             any_req,
  output logic [WIDTH-1:0] exc_target,
  output logic [WIDTH-1:0] next_pc
);

  // Clears the low log2(STEP) bits so redirects always land on a fetch boundary.
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(STEP - 1));

  always_comb begin
    sel        = SEL_SEQ;
    any_req    = exc | eret | jmp | br_taken;
    exc_target = EXC_VECTOR & ALIGN_MASK;
    next_pc    = pc + WIDTH'(STEP);

    if (exc) begin
      sel = SEL_EXC;
    end else if (eret) begin
      sel = SEL_ERET;
    end else if (jmp) begin
      sel = SEL_JMP;
    end else if (br_taken) begin
      sel = SEL_BR;
    end

    unique case (sel)
      SEL_EXC:  next_pc = exc_target;
      SEL_ERET: next_pc = epc & ALIGN_MASK;
      SEL_JMP:  next_pc = jmp_target & ALIGN_MASK;
      SEL_BR:   next_pc = br_target & ALIGN_MASK;
      default:  next_pc = pc + WIDTH'(STEP);
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: sequential advance, prioritised redirects, redirects
// buffered across stalls, and exception PC capture.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_DEFAULT_RESET_VECTOR),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(PC_DEFAULT_EXC_VECTOR),
  parameter int unsigned      STEP         = PC_DEFAULT_STEP
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             exc,
  input  logic             eret,
  output logic [WIDTH-1:0] pc,
  output logic             pc_valid,
  output logic [WIDTH-1:0] epc,
  output logic             redirect_pending
);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             valid_q, pending_q;

  pc_sel_e          sel;
  logic             any_req;
  logic [WIDTH-1:0] exc_target;
  logic [WIDTH-1:0] next_pc;

  pc_next_sel #(
    .WIDTH      (WIDTH),
    .STEP       (STEP),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_next_sel (
    .pc         (pc_q),
    .epc        (epc_q),
    .exc        (exc),
    .eret       (eret),
    .jmp        (jmp),
    .jmp_target (jmp_target),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .sel        (sel),
    .any_req    (any_req),
    .exc_target (exc_target),
    .next_pc    (next_pc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    pend_d  = pend_q;

    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (exc) begin
          epc_d = pc_q;
        end
        if (!stall) begin
          pc_d = next_pc;
        end else if (any_req) begin
          pend_d  = next_pc;
          state_d = PEND;
        end
      end
      PEND: begin
        if (exc) begin
          epc_d = pc_q;
        end
        if (stall) begin
          // Only an exception may replace a buffered redirect.
          if (exc) begin
            pend_d = exc_target;
          end
        end else begin
          pc_d    = exc ? exc_target : pend_q;
          pend_d  = '0;
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= BOOT;
      pc_q      <= RESET_VECTOR;
      epc_q     <= '0;
      pend_q    <= '0;
      valid_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      pend_q    <= pend_d;
      valid_q   <= (state_d != BOOT);
      pending_q <= (state_d == PEND);
    end
  end

  assign pc               = pc_q;
  assign pc_valid         = valid_q;
  assign epc              = epc_q;
  assign redirect_pending = pending_q;

endmodule
